// File: rtl/seg_display_scan_if.sv
// Pin bundle between the user datapath and the multiplexed 7-segment driver.
// The master drives the digit data and display controls; the slave drives the display pins.
interface seg_display_scan_if #(
  parameter int unsigned DIGITS = 4
);
  logic [4*DIGITS-1:0] data;
  logic [DIGITS-1:0]   dp;
  logic                blank_lz;
  logic [3:0]          brightness;
  logic [DIGITS-1:0]   anodes;
  logic [6:0]          segments;
  logic                seg_dp;
  logic                frame_done;

  modport master (
    output data, dp, blank_lz, brightness,
    input  anodes, segments, seg_dp, frame_done
  );

  modport slave (
    input  data, dp, blank_lz, brightness,
    output anodes, segments, seg_dp, frame_done
  );
endinterface

// File: rtl/seg_display_scan.sv
// Time-multiplexed hex 7-segment driver with PWM brightness, leading-zero blanking
// and per-frame input latching so a frame never mixes old and new data.
module seg_display_scan #(
  parameter int unsigned DIGITS           = 4,
  parameter int unsigned CLK_DIV          = 3125,
  parameter bit          ANODE_ACTIVE_LOW = 1'b1,
  parameter bit          SEG_ACTIVE_LOW   = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  seg_display_scan_if.slave bus
);
  localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PW-1:0] PresMax  = PW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DigitMax = DW'(DIGITS - 1);

  logic [PW-1:0]        pres_q, pres_d;
  logic [3:0]           tick_idx_q, tick_idx_d;
  logic [DW-1:0]        digit_q, digit_d;
  logic                 first_q, first_d;
  logic [4*DIGITS-1:0]  data_q, data_d;
  logic [DIGITS-1:0]    dp_q, dp_d;
  logic                 blank_lz_q, blank_lz_d;
  logic [3:0]           bright_q, bright_d;
  logic [DIGITS-1:0]    anodes_q, anodes_d;
  logic [6:0]           segments_q, segments_d;
  logic                 seg_dp_q, seg_dp_d;
  logic                 frame_done_q, frame_done_d;

  logic                 tick, wrap, latch;
  logic [DIGITS-1:0]    lz_blank;

  function automatic logic [6:0] decode(input logic [3:0] n);
    case (n)
      4'h0: decode = 7'b1111110;
      4'h1: decode = 7'b0110000;
      4'h2: decode = 7'b1101101;
      4'h3: decode = 7'b1111001;
      4'h4: decode = 7'b0110011;
      4'h5: decode = 7'b1011011;
      4'h6: decode = 7'b1011111;
      4'h7: decode = 7'b1110000;
      4'h8: decode = 7'b1111111;
      4'h9: decode = 7'b1111011;
      4'hA: decode = 7'b1110111;
      4'hB: decode = 7'b0011111;
      4'hC: decode = 7'b1001110;
      4'hD: decode = 7'b0111101;
      4'hE: decode = 7'b1001111;
      default: decode = 7'b1000111;
    endcase
  endfunction

  always_comb begin
    tick       = (pres_q == PresMax);
    wrap       = tick && (tick_idx_q == 4'hF) && (digit_q == DigitMax);
    // The very first tick after reset also latches, so the display lights without a full frame.
    latch      = wrap || (tick && first_q);
    pres_d     = tick ? '0 : pres_q + 1'b1;
    tick_idx_d = tick ? tick_idx_q + 4'd1 : tick_idx_q;
    digit_d    = digit_q;
    if (tick && (tick_idx_q == 4'hF)) begin
      digit_d = (digit_q == DigitMax) ? '0 : digit_q + 1'b1;
    end
    first_d      = first_q && !tick;
    data_d       = latch ? bus.data       : data_q;
    dp_d         = latch ? bus.dp         : dp_q;
    blank_lz_d   = latch ? bus.blank_lz   : blank_lz_q;
    bright_d     = latch ? bus.brightness : bright_q;
    frame_done_d = wrap;
  end

  // A digit is blanked when it and every more-significant nibble are zero.
  always_comb begin
    logic zero_run;
    zero_run = 1'b1;
    lz_blank = '0;
    for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
      zero_run    = zero_run && (data_q[4*i +: 4] == 4'h0);
      lz_blank[i] = blank_lz_q && zero_run && (i != 0);
    end
  end

  always_comb begin
    logic [DIGITS-1:0] onehot;
    logic [6:0]        lit_seg;
    logic              lit_dp;
    lit_seg = lz_blank[digit_q] ? 7'b0 : decode(data_q[4*digit_q +: 4]);
    lit_dp  = dp_q[digit_q];
    onehot  = (tick_idx_q < bright_q) ? (DIGITS'(1) << digit_q) : '0;
    if (first_q) begin
      onehot  = '0;
      lit_seg = '0;
      lit_dp  = 1'b0;
    end
    anodes_d   = onehot ^ {DIGITS{ANODE_ACTIVE_LOW}};
    segments_d = lit_seg ^ {7{SEG_ACTIVE_LOW}};
    seg_dp_d   = lit_dp ^ SEG_ACTIVE_LOW;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pres_q       <= '0;
      tick_idx_q   <= '0;
      digit_q      <= '0;
      first_q      <= 1'b1;
      data_q       <= '0;
      dp_q         <= '0;
      blank_lz_q   <= 1'b0;
      bright_q     <= '0;
      anodes_q     <= {DIGITS{ANODE_ACTIVE_LOW}};
      segments_q   <= {7{SEG_ACTIVE_LOW}};
      seg_dp_q     <= SEG_ACTIVE_LOW;
      frame_done_q <= 1'b0;
    end else begin
      pres_q       <= pres_d;
      tick_idx_q   <= tick_idx_d;
      digit_q      <= digit_d;
      first_q      <= first_d;
      data_q       <= data_d;
      dp_q         <= dp_d;
      blank_lz_q   <= blank_lz_d;
      bright_q     <= bright_d;
      anodes_q     <= anodes_d;
      segments_q   <= segments_d;
      seg_dp_q     <= seg_dp_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.anodes     = anodes_q;
  assign bus.segments   = segments_q;
  assign bus.seg_dp     = seg_dp_q;
  assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_seg_display_scan.sv
// Scoreboard bench for seg_display_scan: DIGITS=4, CLK_DIV=2, active-low anodes, active-high segments.
module tb_seg_display_scan;
  localparam int unsigned DIGITS  = 4;
  localparam int unsigned CLK_DIV = 2;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fd;
  } pins_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  pins_t exp_q[$];
  logic [6:0] seg_tbl [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                               7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                               7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                               7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

  always #5 clk = ~clk;

  seg_display_scan_if #(.DIGITS(DIGITS)) bus ();

  seg_display_scan #(
    .DIGITS          (DIGITS),
    .CLK_DIV         (CLK_DIV),
    .ANODE_ACTIVE_LOW(1'b1),
    .SEG_ACTIVE_LOW  (1'b0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Expected pins for frame cycle c (0 = first output cycle after frame_done).
  function automatic pins_t model(input logic [15:0] d, input logic [3:0] dpv, input logic blz,
                                  input logic [3:0] br, input int c);
    int    dig = c / 32;
    int    t   = (c % 32) / 2;
    logic  blank;
    pins_t p;
    blank = blz && (dig > 0);
    for (int j = dig; j < 4; j++) if (d[4*j +: 4] != 4'h0) blank = 1'b0;
    p.an = 4'b1111;
    if (t < int'(br)) p.an[dig] = 1'b0;
    p.seg = blank ? 7'b0 : seg_tbl[d[4*dig +: 4]];
    p.dp  = dpv[dig];
    p.fd  = (c == 127);
    return p;
  endfunction

  function automatic pins_t observe();
    return {bus.anodes, bus.segments, bus.seg_dp, bus.frame_done};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_cycles(input logic [15:0] d, input logic [3:0] dpv, input logic blz,
                             input logic [3:0] br, input int c0, input int n);
    for (int c = c0; c < c0 + n; c++) exp_q.push_back(model(d, dpv, blz, br, c));
  endtask

  task automatic wait_frame();
    bit seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      step();
      if (bus.frame_done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL frame_done_timeout: no frame_done within 300 cycles");
    end
  endtask

  task automatic set_inputs(input logic [15:0] d, input logic [3:0] dpv, input logic blz,
                            input logic [3:0] br);
    bus.data       = d;
    bus.dp         = dpv;
    bus.blank_lz   = blz;
    bus.brightness = br;
  endtask

  task automatic test_reset();
    pins_t obs;
    pins_t idle = {4'b1111, 7'b0, 1'b0, 1'b0};
    set_inputs(16'h1234, 4'b0000, 1'b0, 4'd15);
    rst = 1'b1;
    repeat (3) step();
    obs = observe();
    checks++;
    if (obs !== idle) begin
      failures++;
      $display("FAIL reset_idle: got %b want %b", obs, idle);
    end
    @(negedge clk);
    rst = 1'b0;
    step();
    obs = observe();
    checks++;
    if (obs !== idle) begin
      failures++;
      $display("FAIL first_edge_idle: got %b want %b", obs, idle);
    end
    step();
    step();
    obs = observe();
    checks++;
    if (obs !== model(16'h1234, 4'b0, 1'b0, 4'd15, 2)) begin
      failures++;
      $display("FAIL first_latch: got %b want %b", obs, model(16'h1234, 4'b0, 1'b0, 4'd15, 2));
    end
  endtask

  task automatic test_scan();
    pins_t obs, exp;
    int c = 0;
    int active[4] = '{0, 0, 0, 0};
    wait_frame();
    push_cycles(16'h1234, 4'b0000, 1'b0, 4'd15, 0, 128);
    while (exp_q.size() > 0) begin
      step();
      exp = exp_q.pop_front();
      obs = observe();
      if (obs.an !== 4'b1111) active[c/32]++;
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL scan c=%0d: got %b want %b", c, obs, exp);
      end
      c++;
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (active[i] != 30) begin
        failures++;
        $display("FAIL scan_on_time digit%0d: got %0d want 30", i, active[i]);
      end
    end
  endtask

  task automatic test_hex();
    pins_t obs, exp;
    logic [15:0] d;
    for (int v = 0; v < 16; v++) begin
      d = {12'hABC, 4'(v)};
      set_inputs(d, 4'b0000, 1'b0, 4'd15);
      wait_frame();
      push_cycles(d, 4'b0000, 1'b0, 4'd15, 0, 32);
      while (exp_q.size() > 0) begin
        step();
        exp = exp_q.pop_front();
        obs = observe();
        checks++;
        if (obs !== exp) begin
          failures++;
          $display("FAIL hex nibble=%h: got %b want %b", v, obs, exp);
        end
      end
    end
  endtask

  task automatic test_leading_zero();
    logic [15:0] dtab [2] = '{16'h0050, 16'h0000};
    logic [3:0]  ptab [2] = '{4'b0100, 4'b0000};
    pins_t obs, exp;
    for (int s = 0; s < 2; s++) begin
      int c = 0;
      set_inputs(dtab[s], ptab[s], 1'b1, 4'd15);
      wait_frame();
      push_cycles(dtab[s], ptab[s], 1'b1, 4'd15, 0, 128);
      while (exp_q.size() > 0) begin
        step();
        exp = exp_q.pop_front();
        obs = observe();
        checks++;
        if (obs !== exp) begin
          failures++;
          $display("FAIL lz data=%h c=%0d: got %b want %b", dtab[s], c, obs, exp);
        end
        c++;
      end
    end
  endtask

  task automatic test_brightness();
    logic [3:0] btab [2] = '{4'd0, 4'd4};
    int         ontab [2] = '{0, 8};
    pins_t obs, exp;
    for (int s = 0; s < 2; s++) begin
      int c = 0;
      int active = 0;
      set_inputs(16'h1234, 4'b1010, 1'b0, btab[s]);
      wait_frame();
      push_cycles(16'h1234, 4'b1010, 1'b0, btab[s], 0, 128);
      while (exp_q.size() > 0) begin
        step();
        exp = exp_q.pop_front();
        obs = observe();
        if (c >= 32 && c < 64 && obs.an !== 4'b1111) active++;
        checks++;
        if (obs !== exp) begin
          failures++;
          $display("FAIL bright=%0d c=%0d: got %b want %b", btab[s], c, obs, exp);
        end
        c++;
      end
      checks++;
      if (active != ontab[s]) begin
        failures++;
        $display("FAIL bright_on_time=%0d: got %0d want %0d", btab[s], active, ontab[s]);
      end
    end
  endtask

  task automatic test_tear_free();
    pins_t obs, exp;
    int c = 0;
    set_inputs(16'hAAAA, 4'b0000, 1'b0, 4'd15);
    wait_frame();
    push_cycles(16'hAAAA, 4'b0000, 1'b0, 4'd15, 0, 40);
    for (int phase = 0; phase < 3; phase++) begin
      while (exp_q.size() > 0) begin
        step();
        exp = exp_q.pop_front();
        obs = observe();
        checks++;
        if (obs !== exp) begin
          failures++;
          $display("FAIL tear phase=%0d c=%0d: got %b want %b", phase, c, obs, exp);
        end
        c = (c + 1) % 128;
      end
      if (phase == 0) begin
        bus.data = 16'h5555;
        push_cycles(16'hAAAA, 4'b0000, 1'b0, 4'd15, 40, 88);
      end else if (phase == 1) begin
        push_cycles(16'h5555, 4'b0000, 1'b0, 4'd15, 0, 32);
      end
    end
  endtask

  task automatic test_async_reset();
    pins_t obs;
    pins_t idle = {4'b1111, 7'b0, 1'b0, 1'b0};
    int    n = 0;
    bit    seen = 1'b0;
    repeat (45) step();
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    obs = observe();
    checks++;
    if (obs !== idle) begin
      failures++;
      $display("FAIL async_reset_immediate: got %b want %b", obs, idle);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    while (n < 300) begin
      step();
      n++;
      obs = observe();
      if (n == 3) begin
        checks++;
        if (obs !== model(16'h5555, 4'b0, 1'b0, 4'd15, 2)) begin
          failures++;
          $display("FAIL restart_digit0: got %b want %b", obs,
                   model(16'h5555, 4'b0, 1'b0, 4'd15, 2));
        end
      end
      if (obs.fd === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen || n != 128) begin
      failures++;
      $display("FAIL first_frame_done_after_reset: got %0d cycles want 128", n);
    end
  endtask

  initial begin
    set_inputs(16'h0000, 4'b0000, 1'b0, 4'd0);
    test_reset();
    test_scan();
    test_hex();
    test_leading_zero();
    test_brightness();
    test_tear_free();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
